// File: rtl/pc_seq.sv
// Program-flow sequencer: drives the PC load port, holds a call/return stack,
// and takes a single non-nesting level interrupt between control-flow events.
module pc_seq #(
    parameter int               NBITS    = 8,
    parameter int               DEPTH    = 8,
    parameter logic [NBITS-1:0] ISR_ADDR = NBITS'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             jmp,
    input  logic             jz,
    input  logic             zero,
    input  logic             call,
    input  logic             ret,
    input  logic             reti,
    input  logic [NBITS-1:0] target,
    input  logic [NBITS-1:0] addr,
    input  logic             irq,
    input  logic             ie,
    output logic             pc_load,
    output logic [NBITS-1:0] pc_data,
    output logic             flush,
    output logic             in_isr,
    output logic             stk_full,
    output logic             stk_empty,
    output logic [1:0]       err
);

    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SPW = $clog2(DEPTH) + 1;

    typedef enum logic {RUN, SQUASH} state_t;

    state_t           state_reg, state_next;
    logic [SPW-1:0]   sp_reg, sp_next;
    logic             in_isr_reg, in_isr_next;
    logic [1:0]       err_reg, err_next;
    logic [NBITS-1:0] stack_reg [DEPTH];

    logic             push;
    logic [NBITS-1:0] push_val;
    logic [SPW-1:0]   sp_m1;

    assign sp_m1     = sp_reg - SPW'(1);
    assign stk_full  = (sp_reg == SPW'(DEPTH));
    assign stk_empty = (sp_reg == '0);
    assign flush     = (state_reg == SQUASH);
    assign in_isr    = in_isr_reg;
    assign err       = err_reg;

    always_comb begin
        state_next  = RUN;
        sp_next     = sp_reg;
        in_isr_next = in_isr_reg;
        err_next    = err_reg;
        push        = 1'b0;
        push_val    = addr;
        pc_load     = 1'b0;
        pc_data     = '0;
        // Outputs are held quiet while reset is asserted, even between edges.
        if (!rst && state_reg == RUN) begin
            if (ret || reti) begin
                pc_load = 1'b1;
                if (stk_empty) begin
                    err_next[1] = 1'b1;
                end else begin
                    pc_data = stack_reg[sp_m1[AW-1:0]];
                    sp_next = sp_m1;
                end
                if (reti) in_isr_next = 1'b0;
            end else if (call) begin
                pc_load = 1'b1;
                pc_data = target;
                if (stk_full) begin
                    err_next[0] = 1'b1;
                end else begin
                    push    = 1'b1;
                    sp_next = sp_reg + SPW'(1);
                end
            end else if (jmp || (jz && zero)) begin
                pc_load = 1'b1;
                pc_data = target;
            end else if (irq && ie && !in_isr_reg && !stk_full) begin
                // Return to addr-1 so the fetch squashed by this redirect re-executes.
                push        = 1'b1;
                push_val    = addr - NBITS'(1);
                sp_next     = sp_reg + SPW'(1);
                pc_load     = 1'b1;
                pc_data     = ISR_ADDR;
                in_isr_next = 1'b1;
            end
            if (pc_load) state_next = SQUASH;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= RUN;
            sp_reg     <= '0;
            in_isr_reg <= 1'b0;
            err_reg    <= 2'b00;
        end else begin
            state_reg  <= state_next;
            sp_reg     <= sp_next;
            in_isr_reg <= in_isr_next;
            err_reg    <= err_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) stack_reg[sp_reg[AW-1:0]] <= push_val;
    end

endmodule

// File: tb/tb_pc_seq.sv
// Directed bench for pc_seq: call/return, stack limits, interrupt entry/exit,
// arbitration against jumps, squash cycles and asynchronous reset.
module tb_pc_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       jmp, jz, zero, call, ret, reti, irq, ie;
    logic [7:0] target, addr;
    logic       pc_load, flush, in_isr, stk_full, stk_empty;
    logic [7:0] pc_data;
    logic [1:0] err;

    int n_vec = 0;
    int n_err = 0;

    pc_seq #(.NBITS(8), .DEPTH(8), .ISR_ADDR(8'h01)) dut (
        .clk(clk), .rst(rst), .jmp(jmp), .jz(jz), .zero(zero), .call(call),
        .ret(ret), .reti(reti), .target(target), .addr(addr), .irq(irq),
        .ie(ie), .pc_load(pc_load), .pc_data(pc_data), .flush(flush),
        .in_isr(in_isr), .stk_full(stk_full), .stk_empty(stk_empty), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic idle();
        jmp = 0; jz = 0; zero = 0; call = 0; ret = 0; reti = 0; irq = 0;
    endtask

    // Advance one edge; inputs change and comb outputs settle 1 time unit later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        ie = 1; target = 8'h00; addr = 8'h00;
        rst = 1;
        call = 1; target = 8'h40;
        #1;
        chk("rst_load", pc_load, 0);
        chk("rst_data", pc_data, 0);
        chk("rst_flush", flush, 0);
        chk("rst_isr", in_isr, 0);
        chk("rst_err", err, 0);
        chk("rst_empty", stk_empty, 1);
        cyc();
        rst = 0;
        idle();
        cyc();

        // Basic call / squash / return
        addr = 8'h10; call = 1; target = 8'h40; #1;
        chk("call_load", pc_load, 1);
        chk("call_data", pc_data, 8'h40);
        cyc();
        chk("call_flush", flush, 1);
        chk("call_notempty", stk_empty, 0);
        call = 0; jmp = 1; target = 8'h77; #1;
        chk("squash_jmp_ignored", pc_load, 0);
        cyc();
        chk("squash_done", flush, 0);
        jmp = 0; ret = 1; #1;
        chk("ret_data", pc_data, 8'h10);
        chk("ret_load", pc_load, 1);
        cyc();
        chk("ret_flush", flush, 1);
        chk("ret_empty", stk_empty, 1);
        idle(); cyc();

        // Fill the stack, overflow, drain, underflow
        for (int i = 1; i <= 8; i++) begin
            addr = 8'(i); call = 1; target = 8'h80; cyc();
            call = 0; cyc();
        end
        chk("full", stk_full, 1);
        addr = 8'h09; call = 1; target = 8'h50; #1;
        chk("ovf_load", pc_load, 1);
        chk("ovf_data", pc_data, 8'h50);
        cyc();
        chk("ovf_err", err, 2'b01);
        chk("ovf_full", stk_full, 1);
        idle(); cyc();
        for (int i = 8; i >= 1; i--) begin
            ret = 1; #1;
            chk($sformatf("pop_%0d", i), pc_data, 8'(i));
            cyc();
            ret = 0; cyc();
        end
        chk("drain_empty", stk_empty, 1);
        ret = 1; #1;
        chk("unf_data", pc_data, 0);
        chk("unf_load", pc_load, 1);
        cyc();
        chk("unf_err", err, 2'b11);
        chk("unf_empty", stk_empty, 1);
        idle(); cyc();

        // Interrupt entry, no nesting, reti
        irq = 1; addr = 8'h20; #1;
        chk("irq_load", pc_load, 1);
        chk("irq_data", pc_data, 8'h01);
        cyc();
        chk("irq_in_isr", in_isr, 1);
        chk("irq_flush", flush, 1);
        cyc();
        chk("irq_nest_blocked", pc_load, 0);
        irq = 0; reti = 1; #1;
        chk("reti_data", pc_data, 8'h1F);
        cyc();
        chk("reti_clear", in_isr, 0);
        chk("err_sticky", err, 2'b11);
        idle(); cyc();

        // irq loses to jmp, waits through squash, then pushes addr-1
        irq = 1; jmp = 1; target = 8'h33; addr = 8'h30; #1;
        chk("arb_jmp_data", pc_data, 8'h33);
        cyc();
        chk("arb_no_isr", in_isr, 0);
        jmp = 0; addr = 8'h33; #1;
        chk("arb_squash_noirq", pc_load, 0);
        cyc();
        addr = 8'h34; #1;
        chk("arb_irq_data", pc_data, 8'h01);
        cyc();
        chk("arb_in_isr", in_isr, 1);
        irq = 0; cyc();
        ret = 1; #1;
        chk("arb_ret_data", pc_data, 8'h33);
        cyc();
        chk("ret_keeps_isr", in_isr, 1);
        ret = 0; cyc();
        reti = 1; #1;
        chk("reti_empty_data", pc_data, 0);
        cyc();
        chk("reti_empty_clear", in_isr, 0);
        idle(); cyc();

        // jz variants and interrupt enable
        jz = 1; zero = 0; target = 8'h05; #1;
        chk("jz0_load", pc_load, 0);
        cyc();
        chk("jz0_flush", flush, 0);
        zero = 1; #1;
        chk("jz1_data", pc_data, 8'h05);
        cyc();
        chk("jz1_flush", flush, 1);
        idle(); cyc();
        ie = 0; irq = 1; #1;
        chk("ie0_blocked", pc_load, 0);
        cyc();
        irq = 0; ie = 1;

        // Build sp=3 inside an ISR, then reset asynchronously between edges
        addr = 8'h60; call = 1; target = 8'h70; cyc();
        call = 0; cyc();
        addr = 8'h71; call = 1; target = 8'h90; cyc();
        call = 0; cyc();
        addr = 8'h91; irq = 1; cyc();
        irq = 0;
        chk("pre_rst_isr", in_isr, 1);
        chk("pre_rst_flush", flush, 1);
        #2 rst = 1;
        #1;
        chk("arst_isr", in_isr, 0);
        chk("arst_flush", flush, 0);
        chk("arst_err", err, 0);
        chk("arst_empty", stk_empty, 1);
        chk("arst_load", pc_load, 0);
        cyc();
        rst = 0;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
